// File: rtl/bubble_seq_pkg.sv
// Shared types and constants for the bubble access sequencer.
// Holds the FSM state encoding, default geometry and active-low output levels.
package bubble_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEEK      = 3'd1,
        ST_REPLICATE = 3'd2,
        ST_TRANSFER  = 3'd3,
        ST_STOP      = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_e;

    localparam int POSITION_COUNT_DEF = 2053;
    localparam int POS_W_DEF          = 12;

    // Generator controls are active low.
    localparam logic SHIFT_ON  = 1'b0;
    localparam logic SHIFT_OFF = 1'b1;
    localparam logic REP_ON    = 1'b0;
    localparam logic REP_OFF   = 1'b1;

endpackage

// File: rtl/bubble_edge_sync.sv
// Two-flop synchronizer with an optional rising-edge pulse output.
// Edge pulse is one master-clock cycle wide, taken after the synchronizer.
module bubble_edge_sync #(
    parameter bit EDGE_OUT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign level_o = sync_q;

    generate
        if (EDGE_OUT) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign edge_o = sync_q & ~prev_q;
        end else begin : g_level
            assign edge_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bubble_access_sequencer.sv
// Page-access sequencer for the bubble timing generator; tracks loop position.
// Optional bootloop path is built when BUBBLE_BOOTLOOP_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a command, position frozen
// SEEK      | shifting until position reaches the replicate target
// REPLICATE | replicator gate held until the next position edge
// TRANSFER  | shifting TRANSFER_POSITIONS further positions
// STOP      | shift released, waiting for the coil to stop
// DONE      | one-cycle completion pulse
module bubble_access_sequencer
    import bubble_seq_pkg::*;
#(
    parameter int POSITION_COUNT     = POSITION_COUNT_DEF,
    parameter int POS_W              = POS_W_DEF,
    parameter int REPLICATE_OFFSET   = 1,
    parameter int TRANSFER_POSITIONS = 1
) (
    input  logic             master_clock,
    input  logic             master_reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_page,
    input  logic             cmd_bootloop,
    input  logic             cmd_abort,
    output logic             busy,
    output logic             done,
    output logic             done_aborted,
    output logic [POS_W-1:0] current_position,
    output logic             bubble_shift_enable,
    output logic             replicator_enable,
    output logic             bootloop_enable,
    input  logic             position_change,
    input  logic             bubble_access
);

    localparam int TW     = POS_W + 1;
    localparam int XFER_W = (TRANSFER_POSITIONS > 1) ? $clog2(TRANSFER_POSITIONS) : 1;

    localparam logic [TW-1:0]     PC_W      = TW'(POSITION_COUNT);
    localparam logic [TW-1:0]     ADD_W     = TW'(POSITION_COUNT - REPLICATE_OFFSET);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(POSITION_COUNT - 1);
    localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(TRANSFER_POSITIONS - 1);

    seq_state_e        state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  target_q, target_d;
    logic [XFER_W-1:0] xfer_q, xfer_d;
    logic              aborted_q, aborted_d;
    logic              shift_q, shift_d;
    logic              rep_q, rep_d;
    logic              boot_q, boot_d;

    logic              pos_edge;
    logic              access_sync;
    logic              pos_level_unused;
    logic              access_edge_unused;
    logic              accept;
    logic              active;
    logic              abort_hit;
    logic              boot_sel;
    logic [TW-1:0]     target_sum;
    logic [POS_W-1:0]  target_new;
    logic [POS_W-1:0]  pos_inc;

    bubble_edge_sync #(.EDGE_OUT(1'b1)) u_pos_sync (
        .clk_i   (master_clock),
        .rst_ni  (master_reset_n),
        .d_i     (position_change),
        .level_o (pos_level_unused),
        .edge_o  (pos_edge)
    );

    bubble_edge_sync #(.EDGE_OUT(1'b0)) u_access_sync (
        .clk_i   (master_clock),
        .rst_ni  (master_reset_n),
        .d_i     (bubble_access),
        .level_o (access_sync),
        .edge_o  (access_edge_unused)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign active    = (state_q == ST_SEEK) || (state_q == ST_REPLICATE) ||
                       (state_q == ST_TRANSFER);
    assign abort_hit = cmd_abort & active;

    // Page minus offset, modulo the loop; sum stays below 2*POSITION_COUNT.
    assign target_sum = {1'b0, cmd_page} + ADD_W;
    assign target_new = (target_sum >= PC_W) ? POS_W'(target_sum - PC_W)
                                             : target_sum[POS_W-1:0];
    assign pos_inc    = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

`ifdef BUBBLE_BOOTLOOP_EN
    logic boot_lat_q;

    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            boot_lat_q <= 1'b0;
        end else if (accept) begin
            boot_lat_q <= cmd_bootloop;
        end
    end

    assign boot_sel = boot_lat_q;
`else
    logic bootloop_unused;
    assign bootloop_unused = cmd_bootloop;
    assign boot_sel        = 1'b0;
`endif

    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            target_q  <= '0;
            xfer_q    <= '0;
            aborted_q <= 1'b0;
            shift_q   <= SHIFT_OFF;
            rep_q     <= REP_OFF;
            boot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            target_q  <= target_d;
            xfer_q    <= xfer_d;
            aborted_q <= aborted_d;
            shift_q   <= shift_d;
            rep_q     <= rep_d;
            boot_q    <= boot_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        target_d  = target_q;
        xfer_d    = xfer_q;
        aborted_d = aborted_q;

        // The coil can still be turning in STOP/DONE, so every non-idle state counts.
        if (pos_edge && (state_q != ST_IDLE)) begin
            pos_d = pos_inc;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    target_d  = target_new;
                    aborted_d = 1'b0;
                    state_d   = (pos_q == target_new) ? ST_REPLICATE : ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (pos_edge && (pos_inc == target_q)) begin
                    state_d = ST_REPLICATE;
                end
            end
            ST_REPLICATE: begin
                if (pos_edge) begin
                    state_d = ST_TRANSFER;
                    xfer_d  = '0;
                end
            end
            ST_TRANSFER: begin
                if (pos_edge) begin
                    if (xfer_q == XFER_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        xfer_d = xfer_q + XFER_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (!access_sync) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d   = ST_STOP;
            aborted_d = 1'b1;
        end
    end

    // Registered controls follow state_q, except an abort releases them at once.
    always_comb begin
        shift_d = (active && !abort_hit) ? SHIFT_ON : SHIFT_OFF;
        rep_d   = ((state_q == ST_REPLICATE) && !abort_hit && !pos_edge) ? REP_ON : REP_OFF;
        boot_d  = boot_sel && (active || (state_q == ST_STOP));
    end

    assign done                = (state_q == ST_DONE);
    assign done_aborted        = done & aborted_q;
    assign current_position    = pos_q;
    assign bubble_shift_enable = shift_q;
    assign replicator_enable   = rep_q;
    assign bootloop_enable     = boot_q;

endmodule

// File: doc/bubble_access_sequencer.md
# bubble_access_sequencer

Sequencing controller for the bubble timing generator. Accepts one page-access command at a time from the host-side interface. Drives the generator's shift, replicator and bootloop controls, and tracks the absolute bubble loop position by counting `position_change` pulses. Signals completion once the coil has stopped. It sits between the host/bus logic and the timing generator, and runs in the 48 MHz `master_clock` domain.

## Interface
- `POSITION_COUNT`, 2053: bubble positions per full loop rotation; position wraps at `POSITION_COUNT-1`.
- `POS_W`, 12: width of position/page values; must satisfy `2^POS_W >= POSITION_COUNT`.
- `REPLICATE_OFFSET`, 1: positions between replicator gate and the requested page; must be `< POSITION_COUNT`.
- `TRANSFER_POSITIONS`, 1: positions shifted after replication before stopping; must be `>= 1`.
- `master_clock`  in  1  48 MHz system clock.
- `master_reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; command accepted when `cmd_valid & cmd_ready`.
- `cmd_page`  in  POS_W  target page position, `0..POSITION_COUNT-1`.
- `cmd_bootloop`  in  1  access the bootloop instead of data loops.
- `cmd_abort`  in  1  abort the current access (level, sampled each cycle).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `done_aborted`  out  1  valid with `done`; 1 if ended by abort.
- `current_position`  out  POS_W  tracked loop position.
- `bubble_shift_enable`  out  1  active low; 0 = shifting.
- `replicator_enable`  out  1  active low; 0 = replicate.
- `bootloop_enable`  out  1  active high.
- `position_change`  in  1  position pulse from the timing generator; asynchronous to this block's flops.
- `bubble_access`  in  1  coil-run indication from the timing generator (high while driving).

## Operation
- States: IDLE, SEEK, REPLICATE, TRANSFER, STOP, DONE.
- Reset values:
  - state IDLE, `current_position` 0, `bubble_shift_enable` 1, `replicator_enable` 1, `bootloop_enable` 0.
  - `done` 0, `done_aborted` 0, `busy` 0, `cmd_ready` 1.
- **Accept.** On accept, latch `target = (cmd_page + POSITION_COUNT - REPLICATE_OFFSET) mod POSITION_COUNT`, computed in `POS_W+1` bits. Latch `cmd_bootloop`.
- **IDLE to SEEK or REPLICATE.** From IDLE the block goes to SEEK. If `current_position == target` at accept, it goes straight to REPLICATE.
- **SEEK.**
  - Outputs: shift 0, `bootloop_enable` = latched value.
  - On each position edge, `current_position` increments; the value after `POSITION_COUNT-1` is 0.
  - If the incremented value equals `target`, go to REPLICATE.
- **REPLICATE.** `replicator_enable` is 0 until the next position edge, then 1. Go to TRANSFER with transfer counter = 0.
- **TRANSFER.** Count position edges. On edge number `TRANSFER_POSITIONS`, go to STOP.
- **STOP.** Shift 1, replicator 1. Wait for the synchronized `bubble_access` to be 0, then go to DONE.
- **DONE.** `done` = 1 for one cycle, `bootloop_enable` cleared, then IDLE.
- **Position tracking.** `current_position` also counts edges seen in STOP, because the coil may still complete a rotation there. It never counts in IDLE.
- **Abort.**
  - `cmd_abort` high in SEEK, REPLICATE or TRANSFER: next state is STOP, replicator forced to 1 in that cycle, `done_aborted` set on the DONE pulse.
  - Abort in IDLE, STOP or DONE is ignored.
- **Simultaneous events.** A position edge and an abort in the same cycle: the position still increments, and abort wins the state transition.
- **Mid-operation reset.** All outputs return immediately to their reset values (shift and replicator de-asserted); the latched target is discarded.

## Timing
- `position_change` passes through a 2-flop synchronizer plus a rising-edge register. `current_position` updates 3 `master_clock` cycles after `position_change` rises.
- `position_change` must be high ≥2 and low ≥2 `master_clock` cycles; shorter pulses are unspecified.
- `bubble_access` passes through a 2-flop synchronizer (level only), giving 2 cycles latency.
- `bubble_shift_enable`, `replicator_enable` and `bootloop_enable` are registered outputs. They change the cycle after the state change.
- `cmd_ready` is combinational from state. `cmd_ready` is low from the cycle after accept until the cycle after DONE.
- Back-to-back commands: the earliest next accept is the cycle after the `done` pulse.

## Configuration
- Macro `BUBBLE_BOOTLOOP_EN`.
- Defined: bootloop path as described above.
- Undefined:
  - `cmd_bootloop` is ignored.
  - `bootloop_enable` is constant 0.
  - The latch register is removed.

## Structure
- Shared package `bubble_seq_pkg`:
  - state enumeration;
  - default constants `POSITION_COUNT_DEF` = 2053 and `POS_W_DEF` = 12;
  - active-low level constants for the shift and replicator outputs.
- One sub-module, `bubble_edge_sync`: 2-flop synchronizer with optional rising-edge output.
  - Instantiated for `position_change` (edge output).
  - Instantiated for `bubble_access` (level output).

## Test plan
Bench parameters: `POSITION_COUNT` = 16, `POS_W` = 5, `REPLICATE_OFFSET` = 1, `TRANSFER_POSITIONS` = 2.
- Reset, then a command with page 5 from position 0 → 4 edges in SEEK. `replicator_enable` is low between edge 4 and edge 5, shift rises after edge 7, and `done` pulses once `bubble_access` drops. `current_position` = 7.
- Position 15, command with page 1 (target 0) → wrap to 0 triggers REPLICATE after 1 edge.
- Position 4, command with page 5 (target = current) → REPLICATE entered without any SEEK edge.
- Abort during SEEK at position 2 → shift 1 next cycle, replicator never low, `done` = 1 with `done_aborted` = 1.
- `master_reset_n` low in TRANSFER → all outputs at reset values in the same cycle, `cmd_ready` = 1. A subsequent command works from position 0.
- Built with and without `BUBBLE_BOOTLOOP_EN`, command with `cmd_bootloop` = 1 → `bootloop_enable` high SEEK through STOP when enabled, and always 0 when disabled.
